mips_fetch_queue: RTL

Parametrised instruction-fetch front end for the pipelined MIPS core. It replaces the direct `pcF`/`instrF` combinational instruction-memory path with a request/acknowledge memory interface and a DEPTH-entry prefetch queue of {pc, instruction} pairs. The decode stage consumes from the queue under a stall signal, and branch/jump resolution redirects fetch and flushes the queue. The block sits between instruction memory and the fetch/decode pipeline register.

---
 rtl/mips_fetch_queue_if.sv | 24 ++
 rtl/mips_fetch_queue.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mips_fetch_queue_if.sv
// Instruction-memory request/acknowledge bus between the fetch queue (master) and imem (slave).
interface mips_fetch_queue_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/mips_fetch_queue.sv
// Fetch front end: one-outstanding imem request engine feeding a DEPTH-entry {pc, instr} queue,
// drained by decode under stallF and flushed on branch/jump redirect.
module mips_fetch_queue #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC00000
) (
  input  logic                clk,
  input  logic                rst,
  mips_fetch_queue_if.master  imem,
  input  logic                stallF,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                instr_valid,
  output logic [DATA_W-1:0]   instrF,
  output logic [ADDR_W-1:0]   pcF
);
  localparam int unsigned     PtrW     = $clog2(DEPTH);
  localparam int unsigned     CntW     = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e            stateQ, stateD;
  logic [ADDR_W-1:0] fetchPcQ, fetchPcD;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic              discardQ, discardD;
  logic [PtrW-1:0]   rdPtrQ, wrPtrQ;
  logic [CntW-1:0]   countQ, countNext;
  logic [ADDR_W-1:0] pcMem   [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic              pop, push, space;

  assign instr_valid = (countQ != '0);
  assign pop         = instr_valid & ~stallF & ~redirect;
  assign push        = (stateQ == StWait) & imem.imem_ack & ~discardQ & ~redirect;
  assign countNext   = countQ - CntW'(pop) + CntW'(push);
  // A new request is only issued when its response is guaranteed a slot.
  assign space       = (countNext < DepthCnt);

  assign instrF = dataMem[rdPtrQ];
  assign pcF    = pcMem[rdPtrQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ   <= StIdle;
      addrQ    <= RESET_PC;
      fetchPcQ <= RESET_PC;
      discardQ <= 1'b0;
      rdPtrQ   <= '0;
      wrPtrQ   <= '0;
      countQ   <= '0;
    end else begin
      stateQ   <= stateD;
      addrQ    <= addrD;
      fetchPcQ <= fetchPcD;
      discardQ <= discardD;
      if (redirect) begin
        countQ <= '0;
        rdPtrQ <= wrPtrQ;
      end else begin
        countQ <= countNext;
        if (pop)  rdPtrQ <= rdPtrQ + PtrW'(1);
        if (push) wrPtrQ <= wrPtrQ + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pcMem[wrPtrQ]   <= addrQ;
      dataMem[wrPtrQ] <= imem.imem_rdata;
    end
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle:  if (space || redirect) stateD = StWait;
      StWait:  if (imem.imem_ack && !discardQ && !redirect && !space) stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_comb begin
    addrD    = addrQ;
    fetchPcD = fetchPcQ;
    discardD = discardQ;
    case (stateQ)
      StIdle: begin
        if (redirect) begin
          addrD    = redirect_pc;
          fetchPcD = redirect_pc;
        end else if (space) begin
          addrD = fetchPcQ;
        end
      end
      StWait: begin
        if (!imem.imem_ack) begin
          // Outstanding request is now stale; its response gets dropped on arrival.
          if (redirect) begin
            discardD = 1'b1;
            fetchPcD = redirect_pc;
          end
        end else if (redirect) begin
          discardD = 1'b0;
          addrD    = redirect_pc;
          fetchPcD = redirect_pc;
        end else if (discardQ) begin
          discardD = 1'b0;
          addrD    = fetchPcQ;
        end else begin
          fetchPcD = addrQ + ADDR_W'(4);
          if (space) addrD = addrQ + ADDR_W'(4);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    imem.imem_req  = (stateQ == StWait);
    imem.imem_addr = addrQ;
  end
endmodule
